// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the MIPS core.
// Owns the PC and issues word fetches over a req/ready handshake. It resolves
// the next PC (sequential, branch or jump) and feeds {instr, pc+4, valid}
// into the IF/ID register. A one-entry skid buffer catches a response that
// arrives while decode is stalled.
// Optional feature macro: FETCH_PERF_EN adds the perf_fetched and
// perf_stall_cyc counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic [31:0] redirect_pc4,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall_cyc
`endif
);

  typedef enum logic [1:0] {BOOT, FETCH, HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] skid_instr, skid_pc4;

  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] seq_pc;
  logic        accept, drop, capture;
  logic        ifid_from_mem, ifid_from_skid, skid_load;
  logic        unused_offset_bits;

  // The top two offset bits fall off when the word offset is shifted left.
  assign unused_offset_bits = &{1'b0, branch_offset[31:30]};

  // Jump beats branch; the branch sum wraps modulo 2^32.
  assign redirect        = jump | branch_taken;
  assign redirect_target = jump ? {redirect_pc4[31:28], jump_index, 2'b00}
                                : redirect_pc4 + {branch_offset[29:0], 2'b00};
  assign seq_pc          = pc_q + PC_STEP;

  assign imem_req  = (state_q == FETCH);
  assign imem_addr = pc_q;

  // A completing access is wrong-path if any redirect is pending or arriving.
  assign accept         = imem_req && imem_ready;
  assign drop           = accept && (redirect || pend_valid_q);
  assign capture        = accept && !drop && !flush;
  assign ifid_from_mem  = capture && !stall;
  assign skid_load      = capture && stall;
  assign ifid_from_skid = (state_q == HOLD) && !flush && !stall;

  // Next-state, next-PC and pending-redirect logic.
  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    state_d      = state_q;
    pc_d         = pc_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
    unique case (state_q)
      BOOT: begin
        state_d = FETCH;
        if (redirect) pc_d = redirect_target;
      end
      FETCH: begin
        if (imem_ready) begin
          pend_valid_d = 1'b0;
          if (redirect)          pc_d = redirect_target;
          else if (pend_valid_q) pc_d = pend_pc_q;
          else                   pc_d = seq_pc;
          if (skid_load) state_d = HOLD;
        end else if (redirect) begin
          // The address must stay stable mid-access, so park the target.
          pend_valid_d = 1'b1;
          pend_pc_d    = redirect_target;
        end
      end
      HOLD: begin
        if (redirect) pc_d = redirect_target;
        if (flush || !stall) state_d = FETCH;
      end
      default: state_d = BOOT;
    endcase
  end

  // PC, FSM state and pending-redirect registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (!rst_n) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
    end
  end

  // Skid buffer: occupancy is implied by the HOLD state.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the skid data is reset too, so the empty buffer holds known zeros
    // rather than X; it is a single entry, not a memory array.
    if (!rst_n) begin
      skid_instr <= '0;
      skid_pc4   <= '0;
    end else if (skid_load) begin
      skid_instr <= imem_rdata;
      skid_pc4   <= seq_pc;
    end
  end

  // IF/ID register: flush beats load, stall freezes, otherwise a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_instr <= '0;
      ifid_pc4   <= '0;
      ifid_valid <= 1'b0;
    end else if (flush) begin
      ifid_valid <= 1'b0;
    end else if (ifid_from_mem) begin
      ifid_instr <= imem_rdata;
      ifid_pc4   <= seq_pc;
      ifid_valid <= 1'b1;
    end else if (ifid_from_skid) begin
      ifid_instr <= skid_instr;
      ifid_pc4   <= skid_pc4;
      ifid_valid <= 1'b1;
    end else if (!stall) begin
      ifid_valid <= 1'b0;
    end
  end

`ifdef FETCH_PERF_EN
  // Performance counters: instructions written into IF/ID and stalled cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched   <= '0;
      perf_stall_cyc <= '0;
    end else begin
      if (!flush && (ifid_from_mem || ifid_from_skid)) perf_fetched <= perf_fetched + 32'd1;
      if (stall && ifid_valid) perf_stall_cyc <= perf_stall_cyc + 32'd1;
    end
  end
`endif

endmodule
